phasecalc_sched: RTL

- Round-robin scheduler that shares one phasecalc engine (CORDIC rec2pol plus quadrant fix-up) between N_CH requesting channels. Each channel delivers one signed X/Y wind-vector sample.
- The block grants one channel at a time, drives the engine's X/Y/endata sequence (kick, hold, capture), and returns the angle tagged with the channel index.
- It sits between the per-channel X/Y accumulators and the direction output or averaging stage.

---
 rtl/phasecalc_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/phasecalc_sched.sv
// phasecalc_sched: round-robin scheduler sharing one phasecalc (CORDIC rec2pol)
// engine between N_CH channels. Grants one requester at a time, presents its
// X/Y sample to the engine, sequences the endata strobes (kick, hold, capture)
// and returns the resulting angle tagged with the channel index.
module phasecalc_sched #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned CH_W        = 2,
   parameter int unsigned CALC_CYCLES = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  en,
   input  logic [N_CH-1:0]       req,
   input  logic [13*N_CH-1:0]    x_in,
   input  logic [13*N_CH-1:0]    y_in,
   output logic [N_CH-1:0]       ack,
   output logic [12:0]           pc_x,
   output logic [12:0]           pc_y,
   output logic                  pc_endata,
   input  logic [18:0]           pc_angle,
   output logic                  res_valid,
   output logic [CH_W-1:0]       res_chan,
   output logic [18:0]           res_angle,
   output logic                  busy
);

   localparam int unsigned SW    = 13;
   localparam int unsigned AW    = 19;
   localparam int unsigned CNT_W = 8;

   // Most negative X; its magnitude is not representable in the engine's abs().
   localparam logic [SW-1:0] X_MIN     = 13'h1000;
   localparam logic [SW-1:0] X_MIN_SAT = 13'h1001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_KICK,
      S_WAIT,
      S_CAPT,
      S_READ,
      S_DONE
   } state_e;

   state_e              state_q;
   logic [CH_W-1:0]     last_q;
   logic [CH_W-1:0]     grant_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [SW-1:0]       pc_x_q;
   logic [SW-1:0]       pc_y_q;
   logic [N_CH-1:0]     ack_q;
   logic                endata_q;
   logic                res_valid_q;
   logic [CH_W-1:0]     res_chan_q;
   logic [AW-1:0]       res_angle_q;
   logic                busy_q;

   logic                pick_vld_d;
   logic [CH_W-1:0]     pick_idx_d;
   logic [SW-1:0]       pick_x_d;
   logic [SW-1:0]       pick_y_d;

   // Round-robin pick: first set request scanning last+1, last+2, ... mod N_CH.
   always_comb begin
      int unsigned cand;
      pick_vld_d = 1'b0;
      pick_idx_d = '0;
      cand       = 0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         cand = 32'(last_q) + k;
         if (cand >= N_CH) begin
            cand = cand - N_CH;
         end
         if (!pick_vld_d && req[CH_W'(cand)]) begin
            pick_vld_d = 1'b1;
            pick_idx_d = CH_W'(cand);
         end
      end
   end

   // Select the picked channel's sample and clamp X away from the abs() overflow.
   always_comb begin
      logic [SW-1:0] x_sel;
      x_sel    = '0;
      pick_y_d = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (pick_idx_d == CH_W'(i)) begin
            x_sel    = x_in[i*SW +: SW];
            pick_y_d = y_in[i*SW +: SW];
         end
      end
      pick_x_d = (x_sel == X_MIN) ? X_MIN_SAT : x_sel;
   end

   // Job sequencer; every output is a register updated on the state transition.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         last_q      <= CH_W'(N_CH - 1);
         grant_q     <= '0;
         cnt_q       <= '0;
         pc_x_q      <= '0;
         pc_y_q      <= '0;
         ack_q       <= '0;
         endata_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_chan_q  <= '0;
         res_angle_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         ack_q       <= '0;
         endata_q    <= 1'b0;
         res_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (en && pick_vld_d) begin
                  pc_x_q            <= pick_x_d;
                  pc_y_q            <= pick_y_d;
                  grant_q           <= pick_idx_d;
                  last_q            <= pick_idx_d;
                  ack_q[pick_idx_d] <= 1'b1;
                  busy_q            <= 1'b1;
                  state_q           <= S_LOAD;
               end
            end
            S_LOAD: begin
               endata_q <= 1'b1;
               state_q  <= S_KICK;
            end
            S_KICK: begin
               cnt_q   <= CNT_W'(CALC_CYCLES - 1);
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q == '0) begin
                  endata_q <= 1'b1;
                  state_q  <= S_CAPT;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_CAPT: begin
               state_q <= S_READ;
            end
            S_READ: begin
               res_angle_q <= pc_angle;
               res_chan_q  <= grant_q;
               res_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ack       = ack_q;
   assign pc_x      = pc_x_q;
   assign pc_y      = pc_y_q;
   assign pc_endata = endata_q;
   assign res_valid = res_valid_q;
   assign res_chan  = res_chan_q;
   assign res_angle = res_angle_q;
   assign busy      = busy_q;

endmodule
